// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- sequencing constants shared by the MBIST controller and comparator
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int               NUM_ELEMS    = 6;
    localparam int               ELEM_W       = 3;
    localparam logic [ELEM_W-1:0] LAST_ELEM   = ELEM_W'(NUM_ELEMS - 1);
    localparam int               DRAIN_CYCLES = 2;

    // E0 and E5 are single-op elements; E1..E4 are read-then-write
    function automatic logic elem_two_ops(input logic [ELEM_W-1:0] elem);
        return (elem != 3'd0) && (elem != LAST_ELEM);
    endfunction

    function automatic logic elem_down(input logic [ELEM_W-1:0] elem);
        return (elem == 3'd3) || (elem == 3'd4);
    endfunction

    function automatic logic op_is_write(input logic [ELEM_W-1:0] elem, input logic op);
        return (elem == 3'd0) || op;
    endfunction

    // Reads of E2/E4 expect ones; the write of a two-op element inverts its read background
    function automatic logic op_background(input logic [ELEM_W-1:0] elem, input logic op);
        logic read_bg;
        read_bg = (elem == 3'd2) || (elem == 3'd4);
        if (elem == 3'd0) begin
            return 1'b0;
        end
        return op ? ~read_bg : read_bg;
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// rtl/mbist_cmp.sv - two-stage read-compare pipeline with first-fail capture and saturating count
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  rd_valid_i,
    input  logic                  rd_exp_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [ELEM_W-1:0]     rd_elem_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [ELEM_W-1:0]     fail_elem_o,
    output logic [7:0]            fail_count_o
);

    logic                  s1_valid_q, s2_valid_q;
    logic                  s1_exp_q, s2_exp_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
    logic [ELEM_W-1:0]     s1_elem_q, s2_elem_q;

    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [ELEM_W-1:0]     fail_elem_q, fail_elem_d;
    logic [7:0]            fail_count_q, fail_count_d;
    logic                  mismatch;

    assign mismatch = s2_valid_q && (rdata_i != {DATA_WIDTH{s2_exp_q}});

    always_comb begin
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_count_d = fail_count_q;
        if (clear_i) begin
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_elem_d  = '0;
            fail_count_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = s2_addr_q;
                fail_elem_d = s2_elem_q;
            end
            if (fail_count_q != 8'hFF) begin
                fail_count_d = fail_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_exp_q     <= 1'b0;
            s1_addr_q    <= '0;
            s1_elem_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_exp_q     <= 1'b0;
            s2_addr_q    <= '0;
            s2_elem_q    <= '0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            fail_count_q <= '0;
        end else begin
            s1_valid_q   <= rd_valid_i;
            s1_exp_q     <= rd_exp_i;
            s1_addr_q    <= rd_addr_i;
            s1_elem_q    <= rd_elem_i;
            s2_valid_q   <= s1_valid_q;
            s2_exp_q     <= s1_exp_q;
            s2_addr_q    <= s1_addr_q;
            s2_elem_q    <= s1_elem_q;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign fail_o       = fail_q;
    assign fail_addr_o  = fail_addr_q;
    assign fail_elem_o  = fail_elem_q;
    assign fail_count_o = fail_count_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- MBIST sequencer issuing one memory op per cycle
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem,
    output logic [7:0]            fail_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ELEM_W-1:0]     elem_q, elem_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  drain_q, drain_d;

    logic start_ok, elem_end, op_last, run_last, rd_valid;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign elem_end = elem_down(elem_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);
    assign op_last  = !elem_two_ops(elem_q) || op_q;
    assign run_last = (elem_q == LAST_ELEM) && elem_end && op_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            elem_q  <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    elem_d  = '0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                if (!op_last) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (run_last) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                        elem_d  = '0;
                        addr_d  = '0;
                    end else if (elem_end) begin
                        elem_d = elem_q + 3'd1;
                        addr_d = elem_down(elem_q + 3'd1) ? LAST_ADDR : '0;
                    end else begin
                        addr_d = elem_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end
                end
            end
            ST_DRAIN: begin
                // hold off DONE until the last read has left the compare pipeline
                if (drain_q == 1'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        write_read = (state_q == ST_RUN) && op_is_write(elem_q, op_q);
        address    = (state_q == ST_RUN) ? addr_q : '0;
        // memory registers write data, so present the next op's background one cycle early
        wdata      = (state_d == ST_RUN) ? {DATA_WIDTH{op_background(elem_d, op_d)}} : '0;
        rd_valid   = (state_q == ST_RUN) && !op_is_write(elem_q, op_q);
    end

    mbist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .rd_valid_i   (rd_valid),
        .rd_exp_i     (op_background(elem_q, op_q)),
        .rd_addr_i    (addr_q),
        .rd_elem_i    (elem_q),
        .rdata_i      (rdata),
        .fail_o       (fail),
        .fail_addr_o  (fail_addr),
        .fail_elem_o  (fail_elem),
        .fail_count_o (fail_count)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - directed scoreboard bench for mbist_march_ctrl with faulty memory models
module tb_mbist_march_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;

    logic       wr_a, busy_a, done_a, fail_a;
    logic [3:0] addr_a, faddr_a;
    logic [7:0] wdata_a, rdata_a, fcnt_a;
    logic [2:0] felem_a;

    logic       wr_b, busy_b, done_b, fail_b;
    logic [6:0] addr_b, faddr_b;
    logic [7:0] wdata_b, rdata_b, fcnt_b;
    logic [2:0] felem_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [128];
    logic [7:0] wd_a, rd1_a, wd_b, rd1_b;

    typedef struct {
        logic wr;
        int   addr;
        logic bg;
    } op_t;

    op_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  fault_mode = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .write_read(wr_a), .address(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .busy(busy_a), .done(done_a), .fail(fail_a),
        .fail_addr(faddr_a), .fail_elem(felem_a), .fail_count(fcnt_a)
    );

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CAPACITY(127)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .write_read(wr_b), .address(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_addr(faddr_b), .fail_elem(felem_b), .fail_count(fcnt_b)
    );

    // Memory with registered write data and two-cycle read latency; modes 1/2 fault this one
    always_ff @(posedge clk) begin
        wd_a <= wdata_a;
        if (wr_a) begin
            mem_a[addr_a] <= wd_a;
            if (fault_mode == 2 && addr_a == 4'd4) mem_a[5] <= ~mem_a[5];
        end
        rd1_a   <= (fault_mode == 1 && addr_a == 4'd3) ? (mem_a[addr_a] & 8'hFE) : mem_a[addr_a];
        rdata_a <= rd1_a;
    end

    // Mode 3: bit 0 stuck-at-1 at every address
    always_ff @(posedge clk) begin
        wd_b <= wdata_b;
        if (wr_b) mem_b[addr_b] <= wd_b;
        rd1_b   <= (fault_mode == 3) ? (mem_b[addr_b] | 8'h01) : mem_b[addr_b];
        rdata_b <= rd1_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_march(input int n);
        int  nops [6] = '{1, 2, 2, 2, 2, 1};
        bit  down [6] = '{0, 0, 0, 1, 1, 0};
        bit  rbg  [6] = '{0, 0, 1, 0, 1, 0};
        op_t o;
        int  a;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < n; i++) begin
                a = down[e] ? (n - 1 - i) : i;
                o.addr = a;
                if (e == 0) begin
                    o.wr = 1'b1; o.bg = 1'b0; exp_q.push_back(o);
                end else begin
                    o.wr = 1'b0; o.bg = rbg[e]; exp_q.push_back(o);
                    if (nops[e] == 2) begin
                        o.wr = 1'b1; o.bg = !rbg[e]; exp_q.push_back(o);
                    end
                end
            end
        end
    endtask

    // Starts a run at the current negedge and checks every issued op against the scoreboard
    task automatic run_march(input bit big, input int n, input int poke_at, input bit poke_rst);
        op_t         o;
        int          lat;
        logic [7:0]  exp_wd, wd, fc, prev_fc;
        logic [31:0] ad;
        logic        wr, bs, dn;
        lat     = -1;
        prev_fc = 8'd0;
        push_march(n);
        if (big) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 1; k <= 10 * n + 10; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            wr = big ? wr_b : wr_a;
            ad = big ? 32'(addr_b) : 32'(addr_a);
            wd = big ? wdata_b : wdata_a;
            bs = big ? busy_b : busy_a;
            dn = big ? done_b : done_a;
            fc = big ? fcnt_b : fcnt_a;
            if (exp_q.size() > 0) begin
                o = exp_q.pop_front();
                exp_wd = (exp_q.size() > 0) ? {8{exp_q[0].bg}} : 8'h00;
                chk("cmd_write_read", 32'(wr), 32'(o.wr));
                chk("cmd_address", ad, o.addr);
                chk("wdata_ahead", 32'(wd), 32'(exp_wd));
                chk("busy_done_in_run", 32'({bs, dn}), 32'd2);
            end else if (dn) begin
                lat = k - 1;
                break;
            end else begin
                chk("drain_write_read", 32'(wr), 32'd0);
                chk("drain_address", ad, 32'd0);
                chk("drain_busy", 32'(bs), 32'd1);
            end
            if (prev_fc == 8'd255) chk("fail_count_stays_sat", 32'(fc), 32'd255);
            prev_fc = fc;
            if (k == poke_at) begin
                if (poke_rst) return;
                if (big) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        chk("done_latency", lat, 10 * n + 2);
    endtask

    task automatic chk_a_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
        chk({tag, "_fail"}, 32'(fail_a), 32'd0);
        chk({tag, "_fail_count"}, 32'(fcnt_a), 32'd0);
        chk({tag, "_fail_addr"}, 32'(faddr_a), 32'd0);
        chk({tag, "_fail_elem"}, 32'(felem_a), 32'd0);
        chk({tag, "_write_read"}, 32'(wr_a), 32'd0);
        chk({tag, "_address"}, 32'(addr_a), 32'd0);
        chk({tag, "_wdata"}, 32'(wdata_a), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_a_all_zero("reset");
        chk("reset_b_busy", 32'(busy_b), 32'd0);
        chk("reset_b_fail_count", 32'(fcnt_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // fault-free memory
        run_march(1'b0, 16, 0, 1'b0);
        chk("clean_fail", 32'(fail_a), 32'd0);
        chk("clean_fail_count", 32'(fcnt_a), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_held", 32'(done_a), 32'd1);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // bit 0 stuck-at-0 at address 3
        fault_mode = 1;
        run_march(1'b0, 16, 0, 1'b0);
        chk("sa0_fail", 32'(fail_a), 32'd1);
        chk("sa0_fail_elem", 32'(felem_a), 32'd2);
        chk("sa0_fail_addr", 32'(faddr_a), 32'd3);
        chk("sa0_fail_count", 32'(fcnt_a), 32'd2);

        // restart from DONE must clear the previous failure log
        fault_mode = 0;
        run_march(1'b0, 16, 0, 1'b0);
        chk("cleared_fail", 32'(fail_a), 32'd0);
        chk("cleared_fail_count", 32'(fcnt_a), 32'd0);
        chk("cleared_fail_addr", 32'(faddr_a), 32'd0);
        chk("cleared_fail_elem", 32'(felem_a), 32'd0);

        // writes to address 4 invert address 5
        fault_mode = 2;
        run_march(1'b0, 16, 0, 1'b0);
        chk("cf_fail", 32'(fail_a), 32'd1);
        chk("cf_fail_addr", 32'(faddr_a), 32'd5);

        // reset mid-run, then a start coinciding with reset
        fault_mode = 0;
        run_march(1'b0, 16, 50, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_a_all_zero("midrun_reset");
        exp_q.delete();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", 32'(busy_a), 32'd0);
        @(negedge clk);
        chk("start_in_reset_still_idle", 32'(busy_a), 32'd0);
        run_march(1'b0, 16, 0, 1'b0);
        chk("post_reset_fail", 32'(fail_a), 32'd0);

        // start while busy is ignored
        run_march(1'b0, 16, 20, 1'b0);
        chk("busy_start_fail", 32'(fail_a), 32'd0);

        // 128 words with bit 0 stuck-at-1: 384 mismatches saturate the count
        fault_mode = 3;
        run_march(1'b1, 128, 0, 1'b0);
        chk("sat_fail", 32'(fail_b), 32'd1);
        chk("sat_fail_count", 32'(fcnt_b), 32'd255);
        chk("sat_fail_elem", 32'(felem_b), 32'd1);
        chk("sat_fail_addr", 32'(faddr_b), 32'd0);
        repeat (10) @(negedge clk);
        chk("sat_count_held", 32'(fcnt_b), 32'd255);
        chk("sat_done_held", 32'(done_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
